// File: rtl/pipe_stage_reg.sv
// Ready/valid pipeline stage register with optional 2-entry skid buffer.
// Empty entries always hold BUBBLE, so out_data needs no output mux.
module pipe_stage_reg #(
  parameter int               WIDTH  = 96,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter bit               SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  // Encoding equals the occupancy count, so occ is read straight from the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             accept;
  logic             pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      main_reg  <= BUBBLE;
      skid_reg  <= BUBBLE;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = EMPTY;
      main_next  = BUBBLE;
      skid_next  = BUBBLE;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            main_next  = in_data;
          end
        end
        ONE: begin
          if (pop && accept) begin
            main_next = in_data;
          end else if (pop) begin
            state_next = EMPTY;
            main_next  = BUBBLE;
          end else if (accept && SKID) begin
            // Accept while stalled can only happen with a skid entry available.
            state_next = TWO;
            skid_next  = in_data;
          end
        end
        TWO: begin
          if (pop) begin
            state_next = ONE;
            main_next  = skid_reg;
            skid_next  = BUBBLE;
          end
        end
        default: begin
          state_next = EMPTY;
          main_next  = BUBBLE;
          skid_next  = BUBBLE;
        end
      endcase
    end
  end

  always_comb begin
    out_valid = (state_reg != EMPTY);
    out_data  = main_reg;
    occ       = state_reg;
  end

  generate
    if (SKID) begin : g_skid
      // Registered ready breaks the out_ready -> in_ready path; the skid entry absorbs the slack.
      logic in_ready_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          in_ready_reg <= 1'b1;
        end else begin
          in_ready_reg <= (state_next != TWO);
        end
      end
      assign in_ready = in_ready_reg;
    end else begin : g_no_skid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios on SKID=1 and SKID=0 builds,
// then a random ready/valid run against a queue reference model.
module tb_pipe_stage_reg;

  localparam int          W   = 32;
  localparam logic [31:0] BUB = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic         f1, iv1, or1;
  logic [W-1:0] id1;
  logic         ir1, ov1;
  logic [W-1:0] od1;
  logic [1:0]   oc1;
  // SKID=0 instance
  logic         f0, iv0, or0;
  logic [W-1:0] id0;
  logic         ir0, ov0;
  logic [W-1:0] od0;
  logic [1:0]   oc0;

  logic [35:0] s1, s0;
  assign s1 = {ov1, oc1, ir1, od1};
  assign s0 = {ov0, oc0, ir0, od0};

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b1)) u_skid (
    .clk(clk), .rst(rst), .flush(f1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occ(oc1)
  );

  pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b0)) u_noskid (
    .clk(clk), .rst(rst), .flush(f0),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .occ(oc0)
  );

  // One clock of stimulus on the SKID=1 instance; returns 1 time unit after the edge.
  task automatic drive1(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    iv1 = iv; id1 = d; or1 = ordy; f1 = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [35:0] e;
    rst = 1'b1; f1 = 1'b0; f0 = 1'b0; or1 = 1'b0; or0 = 1'b0;
    iv1 = 1'b1; id1 = 32'hA; iv0 = 1'b1; id0 = 32'hA;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; iv1 = 1'b0; iv0 = 1'b0;
    e = {1'b0, 2'd0, 1'b1, BUB};
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL reset_skid: got %h want %h", s1, e); end
    tests_run++;
    if (s0 !== e) begin tests_failed++; $display("FAIL reset_noskid: got %h want %h", s0, e); end
  endtask

  task automatic test_streaming();
    logic [35:0] e;
    for (int i = 1; i <= 3; i++) begin
      drive1(1'b1, W'(i), 1'b1, 1'b0);
      e = {1'b1, 2'd1, 1'b1, W'(i)};
      tests_run++;
      if (s1 !== e) begin tests_failed++; $display("FAIL stream[%0d]: got %h want %h", i, s1, e); end
    end
    drive1(1'b0, '0, 1'b1, 1'b0);
    e = {1'b0, 2'd0, 1'b1, BUB};
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL stream_drain: got %h want %h", s1, e); end
  endtask

  task automatic test_stall_skid();
    logic [35:0] e;
    drive1(1'b1, 32'h10, 1'b0, 1'b0);
    e = {1'b1, 2'd1, 1'b1, 32'h10};
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL stall_one: got %h want %h", s1, e); end
    drive1(1'b1, 32'h11, 1'b0, 1'b0);
    e = {1'b1, 2'd2, 1'b0, 32'h10};
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL stall_two: got %h want %h", s1, e); end
    // Offered payload while full must be refused, not overwrite the skid entry.
    drive1(1'b1, 32'h12, 1'b0, 1'b0);
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL stall_hold: got %h want %h", s1, e); end
    drive1(1'b0, '0, 1'b1, 1'b0);
    e = {1'b1, 2'd1, 1'b1, 32'h11};
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL stall_pop1: got %h want %h", s1, e); end
    drive1(1'b0, '0, 1'b1, 1'b0);
    e = {1'b0, 2'd0, 1'b1, BUB};
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL stall_pop2: got %h want %h", s1, e); end
  endtask

  task automatic test_flush();
    logic [35:0] e;
    drive1(1'b1, 32'h20, 1'b0, 1'b0);
    drive1(1'b1, 32'h21, 1'b0, 1'b0);
    e = {1'b1, 2'd2, 1'b0, 32'h20};
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL flush_fill: got %h want %h", s1, e); end
    drive1(1'b1, 32'h22, 1'b1, 1'b1);
    e = {1'b0, 2'd0, 1'b1, BUB};
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL flush_two: got %h want %h", s1, e); end
    drive1(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL flush_after: got %h want %h", s1, e); end
    // Flush in ONE with an accept that would otherwise succeed.
    drive1(1'b1, 32'h25, 1'b0, 1'b0);
    drive1(1'b1, 32'h26, 1'b0, 1'b1);
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL flush_one: got %h want %h", s1, e); end
    drive1(1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL flush_one_after: got %h want %h", s1, e); end
  endtask

  task automatic test_back_to_back();
    logic [35:0] e;
    drive1(1'b1, 32'h30, 1'b0, 1'b0);
    e = {1'b1, 2'd1, 1'b1, 32'h30};
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL b2b_load: got %h want %h", s1, e); end
    drive1(1'b1, 32'h31, 1'b1, 1'b0);
    e = {1'b1, 2'd1, 1'b1, 32'h31};
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL b2b_swap: got %h want %h", s1, e); end
    drive1(1'b0, '0, 1'b1, 1'b0);
    e = {1'b0, 2'd0, 1'b1, BUB};
    tests_run++;
    if (s1 !== e) begin tests_failed++; $display("FAIL b2b_drain: got %h want %h", s1, e); end
  endtask

  task automatic test_noskid_ready();
    logic [35:0] e;
    iv0 = 1'b1; id0 = 32'h40; or0 = 1'b0; f0 = 1'b0;
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    e = {1'b1, 2'd1, 1'b0, 32'h40};
    tests_run++;
    if (s0 !== e) begin tests_failed++; $display("FAIL noskid_stall: got %h want %h", s0, e); end
    or0 = 1'b1;
    #1;
    e = {1'b1, 2'd1, 1'b1, 32'h40};
    tests_run++;
    if (s0 !== e) begin tests_failed++; $display("FAIL noskid_comb_ready: got %h want %h", s0, e); end
    @(posedge clk);
    #1;
    e = {1'b0, 2'd0, 1'b1, BUB};
    tests_run++;
    if (s0 !== e) begin tests_failed++; $display("FAIL noskid_drain: got %h want %h", s0, e); end
  endtask

  // Reference: a bounded FIFO queue per build; capacity 2 with registered ready,
  // capacity 1 with ready = empty | downstream ready.
  task automatic test_random();
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    logic [35:0]  e;
    int           max_occ0 = 0;
    for (int c = 0; c < 1000; c++) begin
      f1  = ($urandom_range(31) == 0);
      iv1 = 1'($urandom_range(1));
      id1 = $urandom;
      or1 = (c < 500) ? 1'($urandom_range(1)) : ($urandom_range(3) == 0);
      f0  = ($urandom_range(31) == 0);
      iv0 = 1'($urandom_range(1));
      id0 = $urandom;
      or0 = 1'($urandom_range(1));
      @(negedge clk);
      e = {q1.size() != 0, 2'(q1.size()), q1.size() < 2, (q1.size() != 0) ? q1[0] : BUB};
      tests_run++;
      if (s1 !== e) begin tests_failed++; $display("FAIL rand_skid[%0d]: got %h want %h", c, s1, e); end
      e = {q0.size() != 0, 2'(q0.size()), (q0.size() == 0) || or0, (q0.size() != 0) ? q0[0] : BUB};
      tests_run++;
      if (s0 !== e) begin tests_failed++; $display("FAIL rand_noskid[%0d]: got %h want %h", c, s0, e); end
      if (int'(oc0) > max_occ0) max_occ0 = int'(oc0);
      if (f1) begin
        q1.delete();
      end else begin
        logic acc1;
        acc1 = iv1 && (q1.size() < 2);
        if (or1 && q1.size() != 0) void'(q1.pop_front());
        if (acc1) q1.push_back(id1);
      end
      if (f0) begin
        q0.delete();
      end else begin
        logic acc0;
        acc0 = iv0 && ((q0.size() == 0) || or0);
        if (or0 && q0.size() != 0) void'(q0.pop_front());
        if (acc0) q0.push_back(id0);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (max_occ0 > 1) begin tests_failed++; $display("FAIL noskid_max_occ: got %0d want <=1", max_occ0); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_back_to_back();
    test_noskid_ready();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
